// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between a CPU
// read/write port and a read-only video port. CPU has fixed priority,
// but video is forced a slot after STARVE_MAX consecutive denials.
// Read data returns, in issue order, to the port that issued the read.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request (held until accepted)
//   cpu_gnt                   combinational grant; accept = req & gnt
//   cpu_rdata, cpu_rvalid     CPU read return (valid is a 1-cycle pulse)
//   vid_req/addr              video read request (held until accepted)
//   vid_gnt                   combinational grant
//   vid_rdata, vid_rvalid     video read return
//   ram_addr/wdata/we         registered RAM command
//   ram_rdata                 RAM data, valid the cycle after ram_addr is sampled
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]     r_starve_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_vid_rdata;
  logic              r_cpu_rvalid;
  logic              r_vid_rvalid;
  // Return tags: stage 1 = command on the RAM pins,
  // stage 2 = RAM data available on ram_rdata.
  logic              r_t1_vld;
  logic              r_t1_vid;
  logic              r_t2_vld;
  logic              r_t2_vid;

  logic w_starve;
  logic w_cpu_gnt;
  logic w_vid_gnt;
  logic w_rd_acc;

  assign w_starve  = (r_starve_cnt == CW'(STARVE_MAX));
  assign w_cpu_gnt = cpu_req & ~(w_starve & vid_req);
  assign w_vid_gnt = vid_req & ~w_cpu_gnt;
  assign w_rd_acc  = (w_cpu_gnt & ~cpu_we) | w_vid_gnt;

  assign cpu_gnt    = w_cpu_gnt;
  assign vid_gnt    = w_vid_gnt;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign ram_we     = r_ram_we;
  assign cpu_rdata  = r_cpu_rdata;
  assign vid_rdata  = r_vid_rdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign vid_rvalid = r_vid_rvalid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve_cnt <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_we     <= 1'b0;
      r_cpu_rdata  <= '0;
      r_vid_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_vid_rvalid <= 1'b0;
      r_t1_vld     <= 1'b0;
      r_t1_vid     <= 1'b0;
      r_t2_vld     <= 1'b0;
      r_t2_vid     <= 1'b0;
    end else begin
      // Count consecutive denied video cycles; any
      // video accept or idle video cycle restarts it.
      if (vid_req & ~w_vid_gnt) begin
        if (!w_starve)
          r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end

      r_ram_we <= 1'b0;
      if (w_cpu_gnt) begin
        r_ram_addr  <= cpu_addr;
        r_ram_wdata <= cpu_wdata;
        r_ram_we    <= cpu_we;
      end else if (w_vid_gnt) begin
        r_ram_addr  <= vid_addr;
      end

      r_t1_vld <= w_rd_acc;
      r_t1_vid <= w_vid_gnt;
      r_t2_vld <= r_t1_vld;
      r_t2_vid <= r_t1_vid;

      r_cpu_rvalid <= r_t2_vld & ~r_t2_vid;
      r_vid_rvalid <= r_t2_vld &  r_t2_vid;
      if (r_t2_vld & ~r_t2_vid)
        r_cpu_rdata <= ram_rdata;
      if (r_t2_vld & r_t2_vid)
        r_vid_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a RAM model,
// directed scenarios and a randomized two-requester phase.
module tb_ram_arbiter;

  localparam int SM = 4;

  logic        CLK;
  logic        RST;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_gnt, vid_rvalid;
  logic [15:0] vid_rdata;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rdata(vid_rdata),
    .vid_rvalid(vid_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment RAM: synchronous, one access per edge.
  logic [15:0] ram_mem [0:65535];
  always @(posedge CLK) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state.
  typedef struct {
    bit          own;   // 1 = video
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [0:65535];
  int          deny_run;
  logic [15:0] exp_addr, exp_wdata, exp_crd, exp_vrd;
  bit          exp_we;
  bit          rst_prev;
  bit          cpu_took, vid_took;
  int          vid_acc_cnt, vid_rv_cnt;
  int          cyc;
  int          checks, errors;

  initial begin
    cyc = 0; checks = 0; errors = 0;
    deny_run = 0; exp_we = 0;
    exp_addr = '0; exp_wdata = '0;
    exp_crd = '0; exp_vrd = '0;
    rst_prev = 0; cpu_took = 0; vid_took = 0;
    vid_acc_cnt = 0; vid_rv_cnt = 0;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: compares what the DUT shows this
  // cycle, then advances the model across the coming edge.
  always @(negedge CLK) begin : mon
    exp_t e;
    bit   ec, ev, forced;
    if (rst_prev) begin
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_vid_rdata", vid_rdata, 0);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("cpu_rvalid", cpu_rvalid, !e.own);
      chk("vid_rvalid", vid_rvalid, e.own);
      if (e.own) begin
        exp_vrd = e.data;
        vid_rv_cnt++;
      end else begin
        exp_crd = e.data;
      end
    end else begin
      chk("spurious_rvalid", {cpu_rvalid, vid_rvalid}, 0);
    end
    chk("cpu_rdata", cpu_rdata, exp_crd);
    chk("vid_rdata", vid_rdata, exp_vrd);
    chk("ram_we", ram_we, exp_we);
    chk("ram_addr", ram_addr, exp_addr);
    if (exp_we) chk("ram_wdata", ram_wdata, exp_wdata);

    // Video is owed the slot once it has been refused SM times in a row.
    forced = vid_req && (deny_run >= SM);
    ec = cpu_req && !forced;
    ev = vid_req && !ec;
    chk("cpu_gnt", cpu_gnt, ec);
    chk("vid_gnt", vid_gnt, ev);

    if (RST) begin
      q.delete();
      deny_run = 0;
      exp_we = 0; exp_addr = '0; exp_wdata = '0;
      exp_crd = '0; exp_vrd = '0;
      cpu_took = 0; vid_took = 0;
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      cpu_took = ec;
      vid_took = ev;
      exp_we = 0;
      if (ec) begin
        exp_addr = cpu_addr;
        if (cpu_we) begin
          exp_we = 1;
          exp_wdata = cpu_wdata;
          ref_mem[cpu_addr] = cpu_wdata;
        end else begin
          q.push_back('{own: 1'b0, data: ref_mem[cpu_addr],
                        due: cyc + 3});
        end
      end else if (ev) begin
        exp_addr = vid_addr;
        vid_acc_cnt++;
        q.push_back('{own: 1'b1, data: ref_mem[vid_addr],
                      due: cyc + 3});
      end
      if (vid_req && !ev) deny_run = deny_run + 1;
      else                deny_run = 0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : drv
    int n0;
    RST = 1;
    cpu_req = 0; cpu_we = 0;
    cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 16'(i + 16'h0100);
      ref_mem[i] = 16'(i + 16'h0100);
    end
    ram_mem[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    repeat (3) step();
    RST = 0;
    step();

    // CPU read alone.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    step();
    cpu_req = 0;
    repeat (4) step();
    chk("t1_cpu_rdata", cpu_rdata, 16'hBEEF);

    // CPU write then read back.
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    step();
    cpu_we = 0;
    step();
    cpu_req = 0;
    repeat (4) step();
    chk("t2_readback", cpu_rdata, 16'h1234);

    // Starvation: both held, video gets every 5th slot.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0005;
    vid_req = 1; vid_addr = 16'h0006;
    n0 = vid_acc_cnt;
    repeat (20) step();
    chk("t3_vid_slots", vid_acc_cnt - n0, 4);
    cpu_req = 0; vid_req = 0;
    repeat (4) step();

    // Interleave CPU / video / CPU on consecutive edges.
    cpu_req = 1; cpu_addr = 16'h0001;
    step();
    cpu_req = 0; vid_req = 1; vid_addr = 16'h0002;
    step();
    vid_req = 0; cpu_req = 1; cpu_addr = 16'h0003;
    step();
    cpu_req = 0;
    repeat (4) step();
    chk("t4_cpu_rdata", cpu_rdata, 16'h0103);
    chk("t4_vid_rdata", vid_rdata, 16'h0102);

    // Reset the cycle after a read accept.
    cpu_req = 1; cpu_addr = 16'h0010;
    step();
    cpu_req = 0; RST = 1;
    step();
    RST = 0;
    repeat (4) step();
    chk("t5_cpu_rdata", cpu_rdata, 16'h0000);

    // Video stream alone.
    n0 = vid_rv_cnt;
    for (int i = 0; i < 8; i++) begin
      vid_req = 1; vid_addr = 16'(i);
      step();
    end
    vid_req = 0;
    repeat (4) step();
    chk("t6_vid_pulses", vid_rv_cnt - n0, 8);
    chk("t6_vid_rdata", vid_rdata, 16'h0107);

    // Randomized traffic with holds and early drops.
    for (int c = 0; c < 3000; c++) begin
      if (cpu_req && !cpu_took) begin
        if ($urandom_range(15) == 0) cpu_req = 0;
      end else begin
        cpu_req   = ($urandom_range(9) < 6);
        cpu_we    = $urandom_range(1) == 1;
        cpu_addr  = 16'($urandom_range(31));
        cpu_wdata = 16'($urandom);
      end
      if (vid_req && !vid_took) begin
        if ($urandom_range(15) == 0) vid_req = 0;
      end else begin
        vid_req  = ($urandom_range(9) < 5);
        vid_addr = 16'($urandom_range(31));
      end
      step();
    end
    cpu_req = 0; vid_req = 0;
    repeat (6) step();
    chk("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
